branch_predictor: RTL and testbench

Dynamic branch predictor for the five-stage MIPS pipeline. It replaces the static always-flush branch policy with a direct-mapped branch target buffer (BTB) that holds per-entry saturating direction counters. IF uses it for a same-cycle lookup on the fetch PC. MEM, where branches and jumps resolve, feeds outcomes back. The block then flags mispredictions and supplies the redirect PC, so the pipeline flushes only on a wrong guess.

---
 rtl/branch_predictor.sv | 148 ++++++++++++++
 tb/tb_branch_predictor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Predicts in IF from the fetch PC and learns from branch and jump outcomes resolved in MEM.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_en,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] jmp_q, jmp_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_d    [ENTRIES];
  logic [STAT_W-1:0]  stat_br_q, stat_br_d;
  logic [STAT_W-1:0]  stat_mis_q, stat_mis_d;

  logic [IDX_W-1:0] if_idx, u_idx;
  logic [TAG_W-1:0] if_tag, u_tag;
  logic             if_hit, u_hit;
  logic             act, mis_raw;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^if_pc[1:0];

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  // Lookup reads only registered state, so a same-cycle update is seen one cycle later.
  assign pred_taken  = pred_en & if_hit & (jmp_q[if_idx] | ctr_q[if_idx][CTR_W-1]);
  assign pred_target = pred_taken ? target_q[if_idx] : '0;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign act     = upd_is_jump | (upd_is_branch & upd_taken);
  assign mis_raw = upd_valid & ((act != upd_pred_taken) |
                                (act & upd_pred_taken & (upd_target != upd_pred_target)));

  // Flush request is masked during reset so the pipeline sees quiet outputs.
  assign mispredict  = rst_n & mis_raw;
  assign redirect_pc = mispredict ? (act ? upd_target : upd_pc + 32'd4) : '0;

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

  always_comb begin
    valid_d  = valid_q;
    jmp_d    = jmp_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (upd_is_jump) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        jmp_d[u_idx]    = 1'b1;
        ctr_d[u_idx]    = CTR_MAX;
      end else if (upd_is_branch) begin
        if (u_hit) begin
          if (upd_taken) begin
            target_d[u_idx] = upd_target;
            if (ctr_q[u_idx] != CTR_MAX) ctr_d[u_idx] = ctr_q[u_idx] + CTR_W'(1);
          end else if (ctr_q[u_idx] != '0) begin
            ctr_d[u_idx] = ctr_q[u_idx] - CTR_W'(1);
          end
        end else if (upd_taken) begin
          valid_d[u_idx]  = 1'b1;
          tag_d[u_idx]    = u_tag;
          target_d[u_idx] = upd_target;
          jmp_d[u_idx]    = 1'b0;
          ctr_d[u_idx]    = CTR_WT;
        end
      end else if (upd_pred_taken && u_hit) begin
        // A non-control instruction predicted taken means a stale aliased entry.
        valid_d[u_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (stat_clr) begin
      stat_br_d  = '0;
      stat_mis_d = '0;
    end else begin
      if (upd_valid && (upd_is_branch || upd_is_jump) && stat_br_q != STAT_MAX)
        stat_br_d = stat_br_q + STAT_W'(1);
      if (mis_raw && stat_mis_q != STAT_MAX)
        stat_mis_d = stat_mis_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      jmp_q      <= '0;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q    <= valid_d;
      jmp_q      <= jmp_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then random traffic, all checked
// against a table-of-entries reference model held in the bench.
module tb_branch_predictor;
  localparam int ENTRIES  = 16;
  localparam int CTR_W    = 2;
  localparam int STAT_W   = 4;
  localparam int IDX_W    = $clog2(ENTRIES);
  localparam int CTR_MAX  = 2 ** CTR_W - 1;
  localparam int CTR_HALF = 2 ** (CTR_W - 1);
  localparam int STAT_MAX = 2 ** STAT_W - 1;

  logic              clk;
  logic              rstN;
  logic              predEn;
  logic [31:0]       ifPc;
  logic              predTaken;
  logic [31:0]       predTarget;
  logic              updValid;
  logic [31:0]       updPc;
  logic              updIsBranch;
  logic              updIsJump;
  logic              updTaken;
  logic [31:0]       updTarget;
  logic              updPredTaken;
  logic [31:0]       updPredTarget;
  logic              mispredict;
  logic [31:0]       redirectPc;
  logic              statClr;
  logic [STAT_W-1:0] statBranches;
  logic [STAT_W-1:0] statMispredicts;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          valid;
    logic [31:0] tag;
    logic [31:0] target;
    bit          jmp;
    int          ctr;
  } entryT;

  entryT modelTable [ENTRIES];
  int    modelBranches;
  int    modelMispredicts;

  branch_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rstN), .pred_en(predEn), .if_pc(ifPc),
    .pred_taken(predTaken), .pred_target(predTarget),
    .upd_valid(updValid), .upd_pc(updPc), .upd_is_branch(updIsBranch),
    .upd_is_jump(updIsJump), .upd_taken(updTaken), .upd_target(updTarget),
    .upd_pred_taken(updPredTaken), .upd_pred_target(updPredTarget),
    .mispredict(mispredict), .redirect_pc(redirectPc), .stat_clr(statClr),
    .stat_branches(statBranches), .stat_mispredicts(statMispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idxOf(logic [31:0] pc);
    return int'(pc[31:2] % ENTRIES);
  endfunction

  function automatic logic [31:0] tagOf(logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit modelHit(logic [31:0] pc);
    return modelTable[idxOf(pc)].valid && (modelTable[idxOf(pc)].tag == tagOf(pc));
  endfunction

  function automatic bit actualTaken();
    return updIsJump || (updIsBranch && updTaken);
  endfunction

  function automatic bit modelMispredict();
    bit act;
    act = actualTaken();
    return updValid && ((act != updPredTaken) ||
                        (act && updPredTaken && updTarget != updPredTarget));
  endfunction

  function automatic logic [31:0] randPc();
    return (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      modelTable[i].valid  = 1'b0;
      modelTable[i].tag    = '0;
      modelTable[i].target = '0;
      modelTable[i].jmp    = 1'b0;
      modelTable[i].ctr    = CTR_HALF - 1;
    end
    modelBranches    = 0;
    modelMispredicts = 0;
  endtask

  task automatic compare(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", name, observed, expected);
    end
  endtask

  task automatic checkOutput(input string step);
    int          i;
    bit          expTaken, act, expMis;
    logic [31:0] expTarget, expRedirect;
    i           = idxOf(ifPc);
    expTaken    = predEn && modelHit(ifPc) && (modelTable[i].jmp || modelTable[i].ctr >= CTR_HALF);
    expTarget   = expTaken ? modelTable[i].target : 32'h0;
    act         = actualTaken();
    expMis      = modelMispredict();
    expRedirect = expMis ? (act ? updTarget : updPc + 32'd4) : 32'h0;
    compare({step, "/pred_taken"}, 32'(predTaken), 32'(expTaken));
    compare({step, "/pred_target"}, predTarget, expTarget);
    compare({step, "/mispredict"}, 32'(mispredict), 32'(expMis));
    compare({step, "/redirect_pc"}, redirectPc, expRedirect);
    compare({step, "/stat_branches"}, 32'(statBranches), 32'(modelBranches));
    compare({step, "/stat_mispredicts"}, 32'(statMispredicts), 32'(modelMispredicts));
  endtask

  task automatic modelCommit();
    int          i;
    logic [31:0] t;
    bit          hit;
    if (statClr) begin
      modelBranches    = 0;
      modelMispredicts = 0;
    end else begin
      if (updValid && (updIsBranch || updIsJump) && modelBranches < STAT_MAX) modelBranches++;
      if (modelMispredict() && modelMispredicts < STAT_MAX) modelMispredicts++;
    end
    if (!updValid) return;
    i   = idxOf(updPc);
    t   = tagOf(updPc);
    hit = modelHit(updPc);
    if (updIsJump) begin
      modelTable[i].valid  = 1'b1;
      modelTable[i].tag    = t;
      modelTable[i].target = updTarget;
      modelTable[i].jmp    = 1'b1;
      modelTable[i].ctr    = CTR_MAX;
    end else if (updIsBranch) begin
      if (hit) begin
        if (updTaken) begin
          modelTable[i].target = updTarget;
          modelTable[i].ctr    = (modelTable[i].ctr + 1 > CTR_MAX) ? CTR_MAX : modelTable[i].ctr + 1;
        end else begin
          modelTable[i].ctr = (modelTable[i].ctr - 1 < 0) ? 0 : modelTable[i].ctr - 1;
        end
      end else if (updTaken) begin
        modelTable[i].valid  = 1'b1;
        modelTable[i].tag    = t;
        modelTable[i].target = updTarget;
        modelTable[i].jmp    = 1'b0;
        modelTable[i].ctr    = CTR_HALF;
      end
    end else if (updPredTaken && hit) begin
      modelTable[i].valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input bit isBranch, input bit isJump,
                               input bit taken, input logic [31:0] target,
                               input bit pTaken, input logic [31:0] pTarget);
    updValid      = 1'b1;
    updPc         = pc;
    updIsBranch   = isBranch;
    updIsJump     = isJump;
    updTaken      = taken;
    updTarget     = target;
    updPredTaken  = pTaken;
    updPredTarget = pTarget;
  endtask

  task automatic idleUpdate();
    updValid = 1'b0; updPc = '0; updIsBranch = 1'b0; updIsJump = 1'b0; updTaken = 1'b0;
    updTarget = '0; updPredTaken = 1'b0; updPredTarget = '0;
  endtask

  task automatic evalCycle(input string step);
    @(negedge clk);
    checkOutput(step);
  endtask

  task automatic commitCycle();
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  task automatic checkAllZero(input string step);
    compare({step, "/pred_taken"}, 32'(predTaken), 32'h0);
    compare({step, "/pred_target"}, predTarget, 32'h0);
    compare({step, "/mispredict"}, 32'(mispredict), 32'h0);
    compare({step, "/redirect_pc"}, redirectPc, 32'h0);
    compare({step, "/stat_branches"}, 32'(statBranches), 32'h0);
    compare({step, "/stat_mispredicts"}, 32'(statMispredicts), 32'h0);
  endtask

  initial begin
    rstN = 1'b0; predEn = 1'b1; ifPc = 32'h40; statClr = 1'b0;
    idleUpdate();
    modelReset();
    // Drive a mispredicting branch while in reset: outputs must still read 0.
    applyStimulus(32'h40, 1, 0, 1, 32'h80, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("in_reset");
    idleUpdate();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    ifPc = 32'h40;
    evalCycle("reset_lookup");
    compare("reset_lookup/taken_const", 32'(predTaken), 32'h0);
    commitCycle();

    applyStimulus(32'h40, 1, 0, 1, 32'h80, 0, 0);
    evalCycle("beq_first_taken");
    compare("beq_first_taken/mis_const", 32'(mispredict), 32'h1);
    compare("beq_first_taken/redir_const", redirectPc, 32'h80);
    commitCycle();

    idleUpdate();
    evalCycle("beq_learned");
    compare("beq_learned/taken_const", 32'(predTaken), 32'h1);
    compare("beq_learned/target_const", predTarget, 32'h80);
    commitCycle();

    applyStimulus(32'h40, 1, 0, 0, 32'h80, 1, 32'h80);
    evalCycle("beq_nt1");
    compare("beq_nt1/mis_const", 32'(mispredict), 32'h1);
    compare("beq_nt1/redir_const", redirectPc, 32'h44);
    commitCycle();
    idleUpdate();
    evalCycle("beq_nt1_after");
    compare("beq_nt1_after/taken_const", 32'(predTaken), 32'h0);
    commitCycle();

    applyStimulus(32'h40, 1, 0, 0, 32'h80, 0, 0);
    evalCycle("beq_nt2");
    compare("beq_nt2/mis_const", 32'(mispredict), 32'h0);
    commitCycle();

    // Walk the counter into both saturation limits.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(32'h40, 1, 0, 0, 32'h80, 0, 0);
      evalCycle("sat_low");
      commitCycle();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h40, 1, 0, 1, 32'h80, 0, 0);
      evalCycle("sat_high");
      commitCycle();
    end
    applyStimulus(32'h40, 1, 0, 0, 32'h80, 1, 32'h80);
    evalCycle("sat_back");
    commitCycle();
    idleUpdate();
    evalCycle("sat_after");
    compare("sat_after/taken_const", 32'(predTaken), 32'h1);
    commitCycle();

    applyStimulus(32'h100, 0, 1, 0, 32'h200, 0, 0);
    evalCycle("jump_install");
    commitCycle();
    idleUpdate();
    ifPc = 32'h100; predEn = 1'b0;
    evalCycle("jump_pred_off");
    compare("jump_pred_off/taken_const", 32'(predTaken), 32'h0);
    commitCycle();
    predEn = 1'b1;
    evalCycle("jump_pred_on");
    compare("jump_pred_on/taken_const", 32'(predTaken), 32'h1);
    compare("jump_pred_on/target_const", predTarget, 32'h200);
    commitCycle();
    applyStimulus(32'h100, 0, 1, 0, 32'h300, 1, 32'h200);
    evalCycle("jr_new_target");
    compare("jr_new_target/mis_const", 32'(mispredict), 32'h1);
    compare("jr_new_target/redir_const", redirectPc, 32'h300);
    commitCycle();
    idleUpdate();
    evalCycle("jr_after");
    compare("jr_after/target_const", predTarget, 32'h300);
    commitCycle();

    applyStimulus(32'h40, 1, 0, 1, 32'h80, 0, 0);
    evalCycle("alias_a");
    commitCycle();
    applyStimulus(32'h80, 1, 0, 1, 32'hC0, 0, 0);
    evalCycle("alias_b");
    commitCycle();
    idleUpdate();
    ifPc = 32'h40;
    evalCycle("alias_old_miss");
    compare("alias_old_miss/taken_const", 32'(predTaken), 32'h0);
    commitCycle();

    ifPc = 32'h80;
    applyStimulus(32'h80, 1, 0, 0, 32'hC0, 1, 32'hC0);
    evalCycle("same_cycle");
    compare("same_cycle/old_taken_const", 32'(predTaken), 32'h1);
    commitCycle();
    idleUpdate();
    evalCycle("same_cycle_next");
    compare("same_cycle_next/new_taken_const", 32'(predTaken), 32'h0);
    commitCycle();

    applyStimulus(32'h140, 0, 1, 0, 32'h500, 0, 0);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkAllZero("mid_reset");
    modelReset();
    @(posedge clk);
    #1;
    idleUpdate();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    ifPc = 32'h100;
    evalCycle("post_reset_100");
    compare("post_reset_100/taken_const", 32'(predTaken), 32'h0);
    commitCycle();
    ifPc = 32'h140;
    evalCycle("post_reset_140");
    commitCycle();

    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      applyStimulus(randPc(), kind <= 5 || kind == 8, kind >= 6 && kind <= 8,
                    1'($urandom_range(0, 1)), randPc() + 32'h1000,
                    1'($urandom_range(0, 1)), 32'h0);
      updPredTarget = ($urandom_range(0, 1) != 0) ? updTarget : randPc();
      updValid      = ($urandom_range(0, 7) != 0);
      statClr       = ($urandom_range(0, 31) == 0);
      predEn        = ($urandom_range(0, 7) != 0);
      ifPc          = ($urandom_range(0, 3) == 0) ? updPc : randPc();
      evalCycle("random");
      commitCycle();
    end
    statClr = 1'b0; predEn = 1'b1;

    idleUpdate();
    statClr = 1'b1;
    evalCycle("stat_clear");
    commitCycle();
    statClr = 1'b0;
    for (int k = 0; k < STAT_MAX + 4; k++) begin
      applyStimulus(32'h3C4, 0, 0, 0, 32'h0, 1, 32'h600);
      evalCycle("stat_fill");
      commitCycle();
    end
    idleUpdate();
    evalCycle("stat_sat");
    compare("stat_sat/mis_const", 32'(statMispredicts), 32'(STAT_MAX));
    commitCycle();
    applyStimulus(32'h3C4, 1, 0, 1, 32'h700, 0, 0);
    statClr = 1'b1;
    evalCycle("stat_clr_wins");
    commitCycle();
    statClr = 1'b0;
    idleUpdate();
    evalCycle("stat_clr_after");
    compare("stat_clr_after/mis_const", 32'(statMispredicts), 32'h0);
    compare("stat_clr_after/br_const", 32'(statBranches), 32'h0);
    commitCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
